// File: rtl/wb_cmd_fifo_slave.sv
// Wishbone classic slave that buffers management writes in a first-word fall-through
// command FIFO and exposes status, threshold and interrupt-enable registers.
module wb_cmd_fifo_slave #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] ADR_MASK = 32'hFFFF_FF00,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned LW       = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cmd_valid_o,
  output logic [31:0] cmd_data_o,
  input  logic        cmd_ready_i,
  output logic [2:0]  user_irq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);

  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    irq_en_q, irq_en_d;
  logic [7:0]    thresh_q, thresh_d;
  logic [2:0]    irq_q, irq_d;
  logic [31:0]   mem_q [DEPTH];

  logic        req, acc, wr_acc, rd_acc;
  logic [5:0]  idx;
  logic        empty, full, pop, push_req, push_ok, ovf_clr;
  logic [31:0] status, rdata;

  assign req    = wbs_stb_i & wbs_cyc_i & ((wbs_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
  // An access commits only on the edge that raises ack, so every cycle has at most one.
  assign acc    = req & ~ack_q;
  assign wr_acc = acc & wbs_we_i;
  assign rd_acc = acc & ~wbs_we_i;
  assign idx    = wbs_adr_i[7:2];

  assign empty    = (level_q == '0);
  assign full     = (level_q == DepthLvl);
  assign pop      = ~empty & cmd_ready_i;
  assign push_req = wr_acc & (idx == 6'd0) & (wbs_sel_i == 4'hF);
  assign push_ok  = push_req & (~full | pop);
  assign ovf_clr  = wr_acc & (idx == 6'd1) & wbs_sel_i[0] & wbs_dat_i[2];

  always_comb begin
    status         = '0;
    status[0]      = empty;
    status[1]      = full;
    status[2]      = ovf_q;
    status[LW+7:8] = level_q;
    case (idx)
      6'd1:    rdata = status;
      6'd2:    rdata = {29'd0, irq_en_q};
      6'd3:    rdata = {24'd0, thresh_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = acc;
    rdata_d  = rd_acc ? rdata : '0;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - LW'(1);
    end
    // Set wins over a simultaneous write-one-to-clear.
    ovf_d    = (push_req & ~push_ok) | (ovf_q & ~ovf_clr);
    irq_en_d = (wr_acc && idx == 6'd2 && wbs_sel_i[0]) ? wbs_dat_i[2:0] : irq_en_q;
    thresh_d = (wr_acc && idx == 6'd3 && wbs_sel_i[0]) ? wbs_dat_i[7:0] : thresh_q;
    irq_d    = {irq_en_q[2] & ovf_q,
                irq_en_q[1] & (9'(level_q) <= 9'(thresh_q)),
                irq_en_q[0] & empty};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= '0;
      thresh_q <= '0;
      irq_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset: contents are only observable while level is non-zero.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wbs_dat_i;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdata_q;
  assign cmd_valid_o = ~empty;
  assign cmd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign user_irq    = irq_q;

endmodule

// File: tb/tb_wb_cmd_fifo_slave.sv
// Self-checking bench for wb_cmd_fifo_slave: register vector table, scoreboarded
// command stream, and hand sequences for reset, overflow and interrupt timing.
module tb_wb_cmd_fifo_slave;

  localparam logic [31:0] ADataR = 32'h3000_0000;
  localparam logic [31:0] AStat  = 32'h3000_0004;
  localparam logic [31:0] AIrqEn = 32'h3000_0008;
  localparam logic [31:0] AThr   = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [2:0]  irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_ack;
    logic [31:0] exp_rd;
    logic        exp_push;
  } vec_t;
  vec_t vecs[17];

  wb_cmd_fifo_slave dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .cmd_valid_o(cmd_valid),
    .cmd_data_o (cmd_data),
    .cmd_ready_i(cmd_ready),
    .user_irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs only change just after a rising edge, so the negedge view is what the DUT pops on.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected no valid word", cmd_data);
      end else begin
        chk("pop_data", cmd_data, sb_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic got_ack, output logic [31:0] rd);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat = d;
    got_ack = 1'b0;
    rd = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got_ack = 1'b1;
        rd = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic do_wr(input string name, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic exp_push);
    logic        ga;
    logic [31:0] rd;
    if (exp_push) sb_q.push_back(d);
    wb_xfer(1'b1, a, s, d, ga, rd);
    chk({name, "_ack"}, 32'(ga), 32'd1);
  endtask

  task automatic do_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic        ga;
    logic [31:0] rd;
    wb_xfer(1'b0, a, 4'hF, 32'h0, ga, rd);
    chk({name, "_ack"}, 32'(ga), 32'd1);
    chk({name, "_data"}, rd, exp);
  endtask

  task automatic drain(input string name);
    cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!cmd_valid) break;
    end
    cmd_ready = 1'b0;
    chk({name, "_valid"}, 32'(cmd_valid), 32'd0);
    chk({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic        ga;
    logic [31:0] rd;

    vecs[0]  = '{1'b1, ADataR,        4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0,   1'b1};
    vecs[1]  = '{1'b0, AStat,         4'hF, 32'h0,         1'b1, 32'h100, 1'b0};
    vecs[2]  = '{1'b0, ADataR,        4'hF, 32'h0,         1'b1, 32'h0,   1'b0};
    vecs[3]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b1, 32'h0,   1'b0};
    vecs[4]  = '{1'b1, 32'h3000_0100, 4'hF, 32'h55,        1'b0, 32'h0,   1'b0};
    vecs[5]  = '{1'b1, ADataR,        4'h3, 32'h1234,      1'b1, 32'h0,   1'b0};
    vecs[6]  = '{1'b0, AStat,         4'hF, 32'h0,         1'b1, 32'h100, 1'b0};
    vecs[7]  = '{1'b1, AThr,          4'h1, 32'hAB,        1'b1, 32'h0,   1'b0};
    vecs[8]  = '{1'b0, AThr,          4'hF, 32'h0,         1'b1, 32'hAB,  1'b0};
    vecs[9]  = '{1'b1, AIrqEn,        4'h0, 32'h7,         1'b1, 32'h0,   1'b0};
    vecs[10] = '{1'b0, AIrqEn,        4'hF, 32'h0,         1'b1, 32'h0,   1'b0};
    vecs[11] = '{1'b1, AIrqEn,        4'h1, 32'h2,         1'b1, 32'h0,   1'b0};
    vecs[12] = '{1'b0, AIrqEn,        4'hF, 32'h0,         1'b1, 32'h2,   1'b0};
    vecs[13] = '{1'b1, AThr,          4'hF, 32'h0,         1'b1, 32'h0,   1'b0};
    vecs[14] = '{1'b0, AThr,          4'hF, 32'h0,         1'b1, 32'h0,   1'b0};
    vecs[15] = '{1'b0, 32'h3000_00FC, 4'hF, 32'h0,         1'b1, 32'h0,   1'b0};
    vecs[16] = '{1'b0, 32'h2000_0004, 4'hF, 32'h0,         1'b0, 32'h0,   1'b0};

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
    cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_data", cmd_data, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Reset asserted while an ack is on the bus.
    do_wr("rst_en", AIrqEn, 4'h1, 32'h1, 1'b0);
    idle(2);
    chk("rst_irq_pre", 32'(irq), 32'd1);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = ADataR; sel = 4'hF; dat = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    chk("rst_mid_ack_pre", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_valid", 32'(cmd_valid), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_rd("rst_status", AStat, 32'h0000_0001);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].exp_push) sb_q.push_back(vecs[i].dat);
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, ga, rd);
      chk($sformatf("vec%0d_ack", i), 32'(ga), 32'(vecs[i].exp_ack));
      if (vecs[i].exp_ack && !vecs[i].we) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end
    chk("tbl_valid", 32'(cmd_valid), 32'd1);
    chk("tbl_head", cmd_data, 32'hDEAD_BEEF);
    chk("tbl_irq", 32'(irq), 32'd0);
    drain("tbl_drain");
    do_wr("en_off", AIrqEn, 4'h1, 32'h0, 1'b0);

    // Fill past capacity; the ninth word is dropped but still acked.
    for (int i = 1; i <= 9; i++) begin
      do_wr($sformatf("fill%0d", i), ADataR, 4'hF, 32'(i), i <= 8);
      if (i == 1) begin
        chk("push_visible", 32'(cmd_valid), 32'd1);
        chk("push_head", cmd_data, 32'd1);
      end
    end
    do_rd("full_status", AStat, 32'h0000_0806);
    drain("fill_drain");
    do_wr("ovf_clr", AStat, 4'h1, 32'h4, 1'b0);
    do_rd("clr_status", AStat, 32'h0000_0001);

    // Push into a full FIFO on the same edge as a pop.
    for (int i = 0; i < 8; i++) do_wr("refill", ADataR, 4'hF, 32'h10 + 32'(i), 1'b1);
    idle(1);
    cmd_ready = 1'b1;
    do_wr("full_pop_push", ADataR, 4'hF, 32'h18, 1'b1);
    cmd_ready = 1'b0;
    do_rd("full_pop_status", AStat, 32'h0000_0802);
    drain("full_pop_drain");

    // Interrupt timing.
    do_wr("irq_en", AIrqEn, 4'h1, 32'h7, 1'b0);
    do_wr("irq_thr", AThr, 4'h1, 32'h2, 1'b0);
    idle(2);
    chk("irq_empty", 32'(irq), 32'd3);
    for (int i = 0; i < 3; i++) do_wr("irq_push", ADataR, 4'hF, 32'hA0 + 32'(i), 1'b1);
    idle(2);
    chk("irq_lvl3", 32'(irq), 32'd0);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    chk("irq1_lag", 32'(irq[1]), 32'd0);
    @(posedge clk);
    #1;
    chk("irq1_rise", 32'(irq[1]), 32'd1);
    for (int i = 0; i < 7; i++) do_wr("irq_fill", ADataR, 4'hF, 32'hB0 + 32'(i), i < 6);
    idle(2);
    chk("irq_ovf", 32'(irq), 32'd4);
    do_wr("irq_w1c", AStat, 4'h1, 32'h4, 1'b0);
    chk("irq2_lag", 32'(irq[2]), 32'd1);
    @(posedge clk);
    #1;
    chk("irq2_fall", 32'(irq[2]), 32'd0);
    drain("irq_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
